// File: rtl/key_event_classifier.sv
// Key event classifier: turns the debounced key level into single-cycle
// short-press, double-click, long-press and auto-repeat pulses.
module key_event_classifier #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc_d;
  logic             key_q;
  logic             short_q;
  logic             double_q;
  logic             long_q;
  logic             repeat_q;
  logic             busy_q;
  logic             rise;
  logic             fall;

  assign rise      = key_level & ~key_q;
  assign fall      = ~key_level & key_q;
  assign cnt_inc_d = cnt_q + CNT_W'(1);

  // NOTE: every register here uses <= so all branches see the pre-edge
  // values of state_q, cnt_q and key_q, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      // key_q resets high so a key held through reset must be released and
      // pressed again before it can produce a rise.
      key_q    <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      key_q    <= key_level;
      busy_q   <= (state_q != IDLE);
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= PRESS1;
          end
        end

        PRESS1: begin
          // A release on the terminal-count edge wins over the long press.
          if (fall) begin
            state_q <= WAIT2;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_TC) begin
            state_q <= LONG_HOLD;
            cnt_q   <= '0;
            long_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        WAIT2: begin
          if (rise) begin
            state_q <= PRESS2;
            cnt_q   <= '0;
          end else if (cnt_q == DCLICK_TC) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        PRESS2: begin
          cnt_q <= '0;
          if (fall) begin
            state_q  <= IDLE;
            double_q <= 1'b1;
          end
        end

        LONG_HOLD: begin
          if (fall) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == REPEAT_TC) begin
            cnt_q    <= '0;
            repeat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_classifier.sv
// Self-checking bench for key_event_classifier: directed scenarios plus a
// randomized press/gap stream checked against a duration-based event model.
module tb_key_event_classifier;

  localparam int LONG_CNT   = 20;
  localparam int DCLICK_CNT = 8;
  localparam int REPEAT_CNT = 5;
  localparam int CNT_W      = 5;
  localparam int K_SHORT    = 0;
  localparam int K_DOUBLE   = 1;
  localparam int K_LONG     = 2;
  localparam int K_REPEAT   = 3;
  localparam int HIST       = 65536;
  localparam int N_SEQ      = 500;

  typedef struct packed {
    int t;
    int k;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic key_level;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic busy;

  int   edge_cnt  = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   multi_hot = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  logic busy_hist [HIST];
  logic [3:0] pulses_s;

  key_event_classifier #(
    .LONG_CNT  (LONG_CNT),
    .DCLICK_CNT(DCLICK_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_level   (key_level),
    .short_pulse (short_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Outputs seen after edge n are logged with time stamp n.
  always @(negedge clk) begin
    pulses_s = {short_pulse, double_pulse, long_pulse, repeat_pulse};
    if ($countones(pulses_s) > 1) multi_hot++;
    if (short_pulse === 1'b1)  obs_q.push_back(mk_ev(edge_cnt, K_SHORT));
    if (double_pulse === 1'b1) obs_q.push_back(mk_ev(edge_cnt, K_DOUBLE));
    if (long_pulse === 1'b1)   obs_q.push_back(mk_ev(edge_cnt, K_LONG));
    if (repeat_pulse === 1'b1) obs_q.push_back(mk_ev(edge_cnt, K_REPEAT));
    if (edge_cnt < HIST) busy_hist[edge_cnt] = busy;
  end

  function automatic ev_t mk_ev(input int t, input int k);
    ev_t e;
    e.t = t;
    e.k = k;
    return e;
  endfunction

  function automatic int obs_t(input int i);
    return (i < obs_q.size()) ? obs_q[i].t : -1;
  endfunction

  function automatic int obs_k(input int i);
    return (i < obs_q.size()) ? obs_q[i].k : -1;
  endfunction

  function automatic logic busy_at(input int e);
    return (e >= 0 && e < HIST) ? busy_hist[e] : 1'bx;
  endfunction

  // One sample per iteration: the level set here is taken at the next edge.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      key_level = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    key_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({short_pulse, double_pulse, long_pulse, repeat_pulse} !== 4'b0000)
      $display("FAIL reset_pulses got=%b exp=0000",
               {short_pulse, double_pulse, long_pulse, repeat_pulse});
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else n_pass++;
    rst = 1'b0;
    obs_q.delete();
    drive(1'b0, 10);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL reset_idle_events got=%0d exp=0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_short();
    int e0;
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 5);
    drive(1'b0, 20);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL short_count got=%0d exp=1", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_k(0) !== K_SHORT) $display("FAIL short_kind got=%0d exp=%0d", obs_k(0), K_SHORT);
    else n_pass++;
    n_checks++;
    if (obs_t(0) !== e0 + 5 + DCLICK_CNT)
      $display("FAIL short_time got=%0d exp=%0d", obs_t(0), e0 + 5 + DCLICK_CNT);
    else n_pass++;
    n_checks++;
    if (busy_at(e0) !== 1'b0 || busy_at(e0 + 1) !== 1'b1)
      $display("FAIL short_busy_rise got=%b%b exp=01", busy_at(e0), busy_at(e0 + 1));
    else n_pass++;
    n_checks++;
    if (busy_at(e0 + 13) !== 1'b1 || busy_at(e0 + 14) !== 1'b0)
      $display("FAIL short_busy_fall got=%b%b exp=10", busy_at(e0 + 13), busy_at(e0 + 14));
    else n_pass++;
  endtask

  task automatic test_double();
    int e0;
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 4);
    drive(1'b0, 15);
    n_checks++;
    if (obs_q.size() !== 1) $display("FAIL double_count got=%0d exp=1", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_k(0) !== K_DOUBLE) $display("FAIL double_kind got=%0d exp=%0d", obs_k(0), K_DOUBLE);
    else n_pass++;
    n_checks++;
    if (obs_t(0) !== e0 + 12) $display("FAIL double_time got=%0d exp=%0d", obs_t(0), e0 + 12);
    else n_pass++;
    n_checks++;
    if (busy_at(e0 + 13) !== 1'b0) $display("FAIL double_busy_fall got=%b exp=0", busy_at(e0 + 13));
    else n_pass++;
  endtask

  task automatic test_long_repeat();
    int e0;
    int exp_t [3];
    int exp_k [3];
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 32);
    drive(1'b0, 15);
    exp_t[0] = e0 + 20; exp_k[0] = K_LONG;
    exp_t[1] = e0 + 25; exp_k[1] = K_REPEAT;
    exp_t[2] = e0 + 30; exp_k[2] = K_REPEAT;
    n_checks++;
    if (obs_q.size() !== 3) $display("FAIL long_count got=%0d exp=3", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_t(i) !== exp_t[i] || obs_k(i) !== exp_k[i])
        $display("FAIL long_ev%0d got t=%0d k=%0d exp t=%0d k=%0d",
                 i, obs_t(i), obs_k(i), exp_t[i], exp_k[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy_at(e0 + 32) !== 1'b1 || busy_at(e0 + 33) !== 1'b0)
      $display("FAIL long_busy_fall got=%b%b exp=10", busy_at(e0 + 32), busy_at(e0 + 33));
    else n_pass++;
  endtask

  task automatic test_boundary();
    int e0;
    // Release on the long terminal-count edge.
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, LONG_CNT);
    drive(1'b0, 20);
    n_checks++;
    if (obs_q.size() !== 1 || obs_k(0) !== K_SHORT || obs_t(0) !== e0 + LONG_CNT + DCLICK_CNT)
      $display("FAIL bnd_long_tie got n=%0d k=%0d t=%0d exp n=1 k=%0d t=%0d",
               obs_q.size(), obs_k(0), obs_t(0), K_SHORT, e0 + LONG_CNT + DCLICK_CNT);
    else n_pass++;
    // Second rise on the double-click terminal-count edge.
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 3);
    drive(1'b0, DCLICK_CNT);
    drive(1'b1, 2);
    drive(1'b0, 15);
    n_checks++;
    if (obs_q.size() !== 1 || obs_k(0) !== K_DOUBLE || obs_t(0) !== e0 + 3 + DCLICK_CNT + 2)
      $display("FAIL bnd_dclick_tie got n=%0d k=%0d t=%0d exp n=1 k=%0d t=%0d",
               obs_q.size(), obs_k(0), obs_t(0), K_DOUBLE, e0 + 3 + DCLICK_CNT + 2);
    else n_pass++;
    // Release on the repeat terminal-count edge.
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, LONG_CNT + REPEAT_CNT);
    drive(1'b0, 15);
    n_checks++;
    if (obs_q.size() !== 1 || obs_k(0) !== K_LONG || obs_t(0) !== e0 + LONG_CNT)
      $display("FAIL bnd_repeat_tie got n=%0d k=%0d t=%0d exp n=1 k=%0d t=%0d",
               obs_q.size(), obs_k(0), obs_t(0), K_LONG, e0 + LONG_CNT);
    else n_pass++;
    // One cycle longer than the long threshold does give a long press.
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, LONG_CNT + 1);
    drive(1'b0, 15);
    n_checks++;
    if (obs_q.size() !== 1 || obs_k(0) !== K_LONG || obs_t(0) !== e0 + LONG_CNT)
      $display("FAIL bnd_long_min got n=%0d k=%0d t=%0d exp n=1 k=%0d t=%0d",
               obs_q.size(), obs_k(0), obs_t(0), K_LONG, e0 + LONG_CNT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e0;
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 24);
    n_checks++;
    if (obs_q.size() !== 1 || obs_t(0) !== e0 + LONG_CNT)
      $display("FAIL rmid_long got n=%0d t=%0d exp n=1 t=%0d", obs_q.size(), obs_t(0), e0 + LONG_CNT);
    else n_pass++;
    key_level = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({short_pulse, double_pulse, long_pulse, repeat_pulse, busy} !== 5'b00000)
      $display("FAIL rmid_outputs got=%b exp=00000",
               {short_pulse, double_pulse, long_pulse, repeat_pulse, busy});
    else n_pass++;
    rst = 1'b0;
    obs_q.delete();
    drive(1'b1, 30);
    drive(1'b0, 5);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL rmid_held_events got=%0d exp=0", obs_q.size());
    else n_pass++;
    obs_q.delete();
    e0 = edge_cnt + 1;
    drive(1'b1, 4);
    drive(1'b0, 15);
    n_checks++;
    if (obs_q.size() !== 1 || obs_k(0) !== K_SHORT || obs_t(0) !== e0 + 4 + DCLICK_CNT)
      $display("FAIL rmid_next_press got n=%0d k=%0d t=%0d exp n=1 k=%0d t=%0d",
               obs_q.size(), obs_k(0), obs_t(0), K_SHORT, e0 + 4 + DCLICK_CNT);
    else n_pass++;
  endtask

  task automatic test_random();
    int h [N_SEQ];
    int g [N_SEQ];
    int e0, cur, i, fe, de, n_bad;
    for (int s = 0; s < N_SEQ; s++) begin
      case ($urandom_range(0, 3))
        0:       h[s] = int'($urandom_range(1, LONG_CNT));
        1:       h[s] = int'($urandom_range(LONG_CNT - 1, LONG_CNT + 2));
        2:       h[s] = int'($urandom_range(LONG_CNT + 1, LONG_CNT + 3 * REPEAT_CNT + 2));
        default: h[s] = int'($urandom_range(1, 6));
      endcase
      case ($urandom_range(0, 2))
        0:       g[s] = int'($urandom_range(1, DCLICK_CNT - 1));
        1:       g[s] = int'($urandom_range(DCLICK_CNT - 1, DCLICK_CNT + 2));
        default: g[s] = int'($urandom_range(DCLICK_CNT + 1, DCLICK_CNT + 6));
      endcase
    end
    g[N_SEQ-1] = DCLICK_CNT + 10;

    // Expected events from press/gap durations alone.
    exp_q.delete();
    e0  = edge_cnt + 1;
    cur = e0;
    i   = 0;
    while (i < N_SEQ) begin
      fe = cur + h[i];
      if (h[i] > LONG_CNT) begin
        exp_q.push_back(mk_ev(cur + LONG_CNT, K_LONG));
        for (int r = cur + LONG_CNT + REPEAT_CNT; r < fe; r += REPEAT_CNT)
          exp_q.push_back(mk_ev(r, K_REPEAT));
        cur = fe + g[i];
        i   = i + 1;
      end else if (g[i] <= DCLICK_CNT && i + 1 < N_SEQ) begin
        de = fe + g[i] + h[i+1];
        exp_q.push_back(mk_ev(de, K_DOUBLE));
        cur = de + g[i+1];
        i   = i + 2;
      end else begin
        exp_q.push_back(mk_ev(fe + DCLICK_CNT, K_SHORT));
        cur = fe + g[i];
        i   = i + 1;
      end
    end

    obs_q.delete();
    for (int s = 0; s < N_SEQ; s++) begin
      drive(1'b1, h[s]);
      drive(1'b0, g[s]);
    end
    drive(1'b0, 10);

    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    n_bad = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_t(k) !== exp_q[k].t || obs_k(k) !== exp_q[k].k) begin
        n_bad++;
        if (n_bad <= 10)
          $display("FAIL rand_ev%0d got t=%0d k=%0d exp t=%0d k=%0d",
                   k, obs_t(k), obs_k(k), exp_q[k].t, exp_q[k].k);
      end else n_pass++;
    end
    n_checks++;
    if (multi_hot !== 0) $display("FAIL exclusive_pulses got=%0d exp=0", multi_hot);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    key_level = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
